pc_sequencer: RTL

//  Parametrised program-counter sequencer for the RV32I fetch stage.

---
 rtl/pc_pkg.sv | 20 ++
 rtl/sat_counter.sv | 29 ++
 rtl/pc_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Package: pc_pkg
// Shared types and constants for the RV32I fetch-stage program-counter sequencer.
//   pc_state_e        sequencer state (boot bubble, running, halted)
//   INSTR_BYTES       fetch stride in bytes
//   DEF_*             default reset, trap and halt vectors
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT   = 2'd0,
        PC_RUN    = 2'd1,
        PC_HALTED = 2'd2
    } pc_state_e;

    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;
    localparam logic [31:0] DEF_HALT_ADDR    = 32'h0000_004C;

endpackage

// File: rtl/sat_counter.sv
// Module: sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   synchronous, active-high; clears count
//   inc    in   1   add one on this edge (ignored once saturated)
//   count  out  W   current count
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Module: pc_sequencer
// Program-counter sequencer for the RV32I fetch stage. Produces the fetch address and
// pc+4 each cycle, handling trap / redirect / stall priority, misaligned redirect
// rejection, a halt-on-address / resume state machine and a saturating fetch counter.
// Ports:
//   clk              in   1      clock, rising edge
//   reset            in   1      synchronous, active-high
//   stall            in   1      hold pc this cycle
//   redirect_valid   in   1      load redirect_target
//   redirect_target  in   XLEN   branch/jump target
//   trap_req         in   1      force pc to TRAP_VECTOR
//   resume           in   1      leave HALTED, continue at pc+4
//   pc               out  XLEN   current fetch address
//   pc_plus_4        out  XLEN   pc + 4 (wraps)
//   pc_valid         out  1      state is RUN
//   halted           out  1      state is HALTED
//   misaligned       out  1      registered pulse: misaligned redirect was rejected
//   fetch_count      out  CNT_W  accepted fetches, saturating
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned    XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
    parameter bit             HALT_EN      = 1'b1,
    parameter logic [XLEN-1:0] HALT_ADDR    = DEF_HALT_ADDR,
    parameter int unsigned    CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_req,
    input  logic             resume,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus_4,
    output logic             pc_valid,
    output logic             halted,
    output logic             misaligned,
    output logic [CNT_W-1:0] fetch_count
);

    // Vectors must keep pc word aligned, otherwise pc[1:0] could go non-zero.
    if (((RESET_VECTOR % INSTR_BYTES) != 0) || ((TRAP_VECTOR % INSTR_BYTES) != 0) ||
        ((HALT_ADDR % INSTR_BYTES) != 0)) begin : g_bad_vector
        $error("pc_sequencer: RESET_VECTOR, TRAP_VECTOR and HALT_ADDR must be 4-byte aligned");
    end

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misaligned_q, misaligned_d;
    logic            fetch_inc;

    assign pc_plus_4 = pc_q + XLEN'(INSTR_BYTES);
    assign pc        = pc_q;
    assign pc_valid  = (state_q == PC_RUN);
    assign halted    = (state_q == PC_HALTED);
    assign misaligned = misaligned_q;

    // Single priority chain for the next pc.
    always_comb begin
        pc_d         = pc_q;
        state_d      = state_q;
        misaligned_d = 1'b0;
        case (state_q)
            PC_BOOT: begin
                state_d = PC_RUN;
            end
            PC_RUN: begin
                if (trap_req) begin
                    pc_d = TRAP_VECTOR;
                end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                    pc_d         = TRAP_VECTOR;
                    misaligned_d = 1'b1;
                end else if (redirect_valid) begin
                    pc_d = redirect_target;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (HALT_EN && (pc_q == HALT_ADDR)) begin
                    state_d = PC_HALTED;
                end else begin
                    pc_d = pc_plus_4;
                end
            end
            PC_HALTED: begin
                if (trap_req) begin
                    pc_d    = TRAP_VECTOR;
                    state_d = PC_RUN;
                end else if (resume) begin
                    pc_d    = pc_plus_4;
                    state_d = PC_RUN;
                end
            end
            default: begin
                // Unreachable encoding: recover through the boot bubble.
                state_d = PC_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            state_q      <= PC_BOOT;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            state_q      <= state_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Every non-stalled RUN cycle is an accepted fetch, whatever the next pc is.
    assign fetch_inc = (state_q == PC_RUN) && !stall;

    sat_counter #(
        .W (CNT_W)
    ) u_fetch_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (fetch_inc),
        .count (fetch_count)
    );

endmodule
